// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Holds the mem_op encodings, funct3/size codes, FSM state type, reset/default constants and
// small decode helpers used by mem_lsu and lsu_lane_fmt.
package mem_lsu_pkg;

    // mem_op_i encodings: [3]=memory access, [2:0]=funct3. Stores reuse the funct3 of the
    // matching load with mem_we_i=1 (SB=LB, SH=LH, SW=LW).
    localparam logic [3:0] OP_LB  = 4'b1000;
    localparam logic [3:0] OP_LH  = 4'b1001;
    localparam logic [3:0] OP_LW  = 4'b1010;
    localparam logic [3:0] OP_LBU = 4'b1100;
    localparam logic [3:0] OP_LHU = 4'b1101;

    localparam logic [2:0] F3_B  = OP_LB[2:0];
    localparam logic [2:0] F3_H  = OP_LH[2:0];
    localparam logic [2:0] F3_W  = OP_LW[2:0];
    localparam logic [2:0] F3_BU = OP_LBU[2:0];
    localparam logic [2:0] F3_HU = OP_LHU[2:0];

    // Access size is funct3[1:0].
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] ZERO          = 32'h0000_0000;
    localparam logic [4:0]  ZERO_REG      = 5'd0;
    localparam logic        WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } lsu_state_e;

    // Stores only exist for B/H/W; loads additionally have the unsigned B/H forms.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatter for the load/store unit (purely combinational).
// Request side: byte enables and replicated write data for a new access.
//   req_size_i    access size (funct3[1:0])     req_addr_lo_i  byte offset in word
//   req_data_i    raw store data                be_o / wdata_o bus lane enables / data
// Load side: extracts and extends the addressed byte/half from the returned bus word.
//   ld_funct3_i   latched funct3                ld_addr_lo_i   latched byte offset
//   rdata_i       bus read data                 ldata_o        writeback value
module lsu_lane_fmt
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = ZERO;
        case (req_size_i)
            SZ_B: begin
                be_o    = 4'b0001 << req_addr_lo_i;
                wdata_o = {4{req_data_i[7:0]}};
            end
            SZ_H: begin
                be_o    = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{req_data_i[15:0]}};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = req_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = rdata_i[7:0];
        case (ld_addr_lo_i)
            2'd0: ld_byte = rdata_i[7:0];
            2'd1: ld_byte = rdata_i[15:8];
            2'd2: ld_byte = rdata_i[23:16];
            2'd3: ld_byte = rdata_i[31:24];
            default: ;
        endcase
        // Halves are always aligned here, so only addr[1] selects.
        ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        ldata_o = ZERO;
        case (ld_funct3_i)
            F3_B:  ldata_o = {{24{ld_byte[7]}}, ld_byte};
            F3_H:  ldata_o = {{16{ld_half[15]}}, ld_half};
            F3_W:  ldata_o = rdata_i;
            F3_BU: ldata_o = {24'h0, ld_byte};
            F3_HU: ldata_o = {16'h0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit.
// Accepts one request at a time from the exe/mem register, drives a single-outstanding req/ack
// bus, and presents a one-cycle writeback pulse to the mem/wb register.
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   req_valid_i / req_ready_o   request handshake; mem_* and reg_* carry the request
//   wb_valid_o, reg_*_o         writeback pulse and fields
//   stall_o                     high while a bus access is in flight
//   misalign_o                  pulse when a misaligned access is dropped
//   bus_*                       word-aligned bus with byte enables
// Optional build macro MEM_LSU_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter, an ack timeout
// counter and the bus_err_o port.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RADDR_WIDTH = 5
`ifdef MEM_LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [DATA_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic                   mem_we_i,
    input  logic [3:0]             mem_op_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    output logic                   wb_valid_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    output logic                   stall_o,
    output logic                   misalign_o,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [DATA_WIDTH-1:0]  bus_addr_o,
    output logic [3:0]             bus_be_o,
    output logic [DATA_WIDTH-1:0]  bus_wdata_o,
    input  logic                   bus_ack_i,
    input  logic [DATA_WIDTH-1:0]  bus_rdata_i
`ifdef MEM_LSU_TIMEOUT_EN
    ,
    output logic                   bus_err_o
`endif
);

    lsu_state_e state_q;

    logic                   req_ready_q, stall_q, wb_valid_q, misalign_q;
    logic [RADDR_WIDTH-1:0] reg_waddr_q;
    logic                   reg_we_q;
    logic [DATA_WIDTH-1:0]  reg_wdata_q;
    logic                   bus_req_q, bus_we_q;
    logic [DATA_WIDTH-1:0]  bus_addr_q, bus_wdata_q;
    logic [3:0]             bus_be_q;

    // Request fields kept for the response cycle.
    logic                   is_load_q;
    logic [2:0]             ld_funct3_q;
    logic [1:0]             addr_lo_q;
    logic                   lat_we_q;
    logic [RADDR_WIDTH-1:0] lat_waddr_q;

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;
    logic            bus_err_q;
`endif

    logic        accept, is_access, is_misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_ldata;

    assign accept        = req_valid_i & req_ready_q;
    // Undefined funct3 (or a store with an unsigned-load funct3) falls back to pass-through.
    assign is_access     = mem_op_i[3] & funct3_legal(mem_op_i[2:0], mem_we_i);
    assign is_misaligned = misaligned(mem_op_i[1:0], mem_addr_i[1:0]);

    lsu_lane_fmt u_lane_fmt (
        .req_size_i    (mem_op_i[1:0]),
        .req_addr_lo_i (mem_addr_i[1:0]),
        .req_data_i    (mem_data_i),
        .be_o          (lane_be),
        .wdata_o       (lane_wdata),
        .ld_funct3_i   (ld_funct3_q),
        .ld_addr_lo_i  (addr_lo_q),
        .rdata_i       (bus_rdata_i),
        .ldata_o       (lane_ldata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            stall_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            reg_waddr_q <= ZERO_REG;
            reg_we_q    <= WRITE_DISABLE;
            reg_wdata_q <= ZERO;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= ZERO;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= ZERO;
            is_load_q   <= 1'b0;
            ld_funct3_q <= 3'd0;
            addr_lo_q   <= 2'd0;
            lat_we_q    <= 1'b0;
            lat_waddr_q <= ZERO_REG;
`ifdef MEM_LSU_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            // Writeback fields are pulses: cleared unless set below.
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            reg_waddr_q <= ZERO_REG;
            reg_we_q    <= WRITE_DISABLE;
            reg_wdata_q <= ZERO;
`ifdef MEM_LSU_TIMEOUT_EN
            bus_err_q   <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!is_access) begin
                            wb_valid_q  <= 1'b1;
                            reg_waddr_q <= reg_waddr_i;
                            reg_we_q    <= mem_op_i[3] ? WRITE_DISABLE : reg_we_i;
                            reg_wdata_q <= reg_wdata_i;
                        end else if (is_misaligned) begin
                            wb_valid_q  <= 1'b1;
                            misalign_q  <= 1'b1;
                            reg_waddr_q <= reg_waddr_i;
                        end else begin
                            state_q     <= StBus;
                            req_ready_q <= 1'b0;
                            stall_q     <= 1'b1;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mem_we_i;
                            bus_addr_q  <= {mem_addr_i[DATA_WIDTH-1:2], 2'b00};
                            bus_be_q    <= lane_be;
                            bus_wdata_q <= mem_we_i ? lane_wdata : ZERO;
                            is_load_q   <= ~mem_we_i;
                            ld_funct3_q <= mem_op_i[2:0];
                            addr_lo_q   <= mem_addr_i[1:0];
                            lat_we_q    <= reg_we_i;
                            lat_waddr_q <= reg_waddr_i;
`ifdef MEM_LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end
                    end
                end
                StBus: begin
                    if (bus_ack_i) begin
                        state_q     <= StResp;
                        stall_q     <= 1'b0;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= ZERO;
                        bus_be_q    <= 4'b0000;
                        bus_wdata_q <= ZERO;
                        wb_valid_q  <= 1'b1;
                        reg_waddr_q <= lat_waddr_q;
                        reg_we_q    <= is_load_q ? lat_we_q : WRITE_DISABLE;
                        reg_wdata_q <= is_load_q ? lane_ldata : ZERO;
`ifdef MEM_LSU_TIMEOUT_EN
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        // Give up: the response cycle reports the error with no register write.
                        state_q     <= StResp;
                        stall_q     <= 1'b0;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= ZERO;
                        bus_be_q    <= 4'b0000;
                        bus_wdata_q <= ZERO;
                        wb_valid_q  <= 1'b1;
                        bus_err_q   <= 1'b1;
                        reg_waddr_q <= lat_waddr_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    stall_q     <= 1'b0;
                    bus_req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign stall_o     = stall_q;
    assign wb_valid_o  = wb_valid_q;
    assign misalign_o  = misalign_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_we_o    = reg_we_q;
    assign reg_wdata_o = reg_wdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;
`ifdef MEM_LSU_TIMEOUT_EN
    assign bus_err_o   = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand-written multi-cycle sequences
// and randomized transactions checked against a byte-level reference model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i, req_ready_o;
    logic [31:0] mem_addr_i, mem_data_i;
    logic        mem_we_i;
    logic [3:0]  mem_op_i;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic        reg_we_i, reg_we_o;
    logic [31:0] reg_wdata_i, reg_wdata_o;
    logic        wb_valid_o, stall_o, misalign_o;
    logic        bus_req_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
`ifdef MEM_LSU_TIMEOUT_EN
    logic        bus_err_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    mem_lsu #(
        .DATA_WIDTH  (32),
        .RADDR_WIDTH (5)
`ifdef MEM_LSU_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (4)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_we_i    (mem_we_i),
        .mem_op_i    (mem_op_i),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .wb_valid_o  (wb_valid_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
`ifdef MEM_LSU_TIMEOUT_EN
        ,
        .bus_err_o   (bus_err_o)
`endif
    );

    typedef struct {
        logic [3:0]  op;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        rwe;
        logic [31:0] rwdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_bus;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic        exp_wb_we;
        logic [31:0] exp_wb_wdata;
        logic        chk_wdata;
    } txn_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: works in terms of access size in bytes and byte offsets.
    function automatic txn_t model(input logic [3:0] op, input logic we, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [4:0] waddr,
                                   input logic rwe, input logic [31:0] rwdata,
                                   input logic [31:0] rdata, input int delay);
        txn_t t;
        int sz, off;
        logic [31:0] mask, v;
        t = '{op, we, addr, data, waddr, rwe, rwdata, rdata, delay,
              1'b0, 1'b0, 4'b0, 32'h0, 1'b0, 32'h0, 1'b1};
        if (!op[3]) begin
            t.exp_wb_we = rwe;
            t.exp_wb_wdata = rwdata;
        end else if (op[2:0] == 3'd3 || op[2:0] >= 3'd6 || (we && op[2])) begin
            t.exp_wb_wdata = rwdata;
        end else begin
            sz = 1 << int'(op[1:0]);
            off = int'(addr[1:0]);
            if ((off % sz) != 0) begin
                t.exp_mis = 1'b1;
                t.chk_wdata = 1'b0;
            end else begin
                t.exp_bus = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    t.exp_be[k] = (k >= off) && (k < off + sz);
                    t.exp_bwdata[8*k +: 8] = data[8*(k % sz) +: 8];
                end
                if (!we) begin
                    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
                    v = (rdata >> (8 * off)) & mask;
                    if (!op[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
                    t.exp_wb_we = rwe;
                    t.exp_wb_wdata = v;
                end
            end
        end
        return t;
    endfunction

    task automatic run_txn(input string tag, input txn_t t);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        mem_op_i = t.op;
        mem_we_i = t.we;
        mem_addr_i = t.addr;
        mem_data_i = t.data;
        reg_waddr_i = t.waddr;
        reg_we_i = t.rwe;
        reg_wdata_i = t.rwdata;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (!t.exp_bus) begin
            chkb({tag, " wb_valid"}, wb_valid_o, 1'b1);
            chkb({tag, " misalign"}, misalign_o, t.exp_mis);
            chkb({tag, " bus_req"}, bus_req_o, 1'b0);
            chkb({tag, " reg_we"}, reg_we_o, t.exp_wb_we);
            chkb({tag, " stall"}, stall_o, 1'b0);
            chkb({tag, " req_ready"}, req_ready_o, 1'b1);
            if (t.chk_wdata) begin
                chk({tag, " reg_wdata"}, reg_wdata_o, t.exp_wb_wdata);
                chk({tag, " reg_waddr"}, {27'h0, reg_waddr_o}, {27'h0, t.waddr});
            end
        end else begin
            for (int c = 1; c <= t.delay; c++) begin
                chkb({tag, " bus_req"}, bus_req_o, 1'b1);
                chkb({tag, " stall"}, stall_o, 1'b1);
                chkb({tag, " req_ready"}, req_ready_o, 1'b0);
                chkb({tag, " wb_valid"}, wb_valid_o, 1'b0);
                chkb({tag, " bus_we"}, bus_we_o, t.we);
                chk({tag, " bus_addr"}, bus_addr_o, {t.addr[31:2], 2'b00});
                chk({tag, " bus_be"}, {28'h0, bus_be_o}, {28'h0, t.exp_be});
                if (t.we) chk({tag, " bus_wdata"}, bus_wdata_o, t.exp_bwdata);
                if (c == t.delay) begin
                    bus_ack_i = 1'b1;
                    bus_rdata_i = t.rdata;
                end
                @(posedge clk_i);
                @(negedge clk_i);
            end
            bus_ack_i = 1'b0;
            bus_rdata_i = $urandom;
            chkb({tag, " resp wb_valid"}, wb_valid_o, 1'b1);
            chkb({tag, " resp reg_we"}, reg_we_o, t.exp_wb_we);
            chk({tag, " resp reg_wdata"}, reg_wdata_o, t.exp_wb_wdata);
            chk({tag, " resp reg_waddr"}, {27'h0, reg_waddr_o}, {27'h0, t.waddr});
            chkb({tag, " resp stall"}, stall_o, 1'b0);
            chkb({tag, " resp req_ready"}, req_ready_o, 1'b0);
            chkb({tag, " resp bus_req"}, bus_req_o, 1'b0);
            @(negedge clk_i);
            chkb({tag, " after wb_valid"}, wb_valid_o, 1'b0);
            chkb({tag, " after req_ready"}, req_ready_o, 1'b1);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chkb({tag, " req_ready"}, req_ready_o, 1'b1);
        chkb({tag, " wb_valid"}, wb_valid_o, 1'b0);
        chkb({tag, " stall"}, stall_o, 1'b0);
        chkb({tag, " misalign"}, misalign_o, 1'b0);
        chkb({tag, " bus_req"}, bus_req_o, 1'b0);
        chkb({tag, " bus_we"}, bus_we_o, 1'b0);
        chkb({tag, " reg_we"}, reg_we_o, 1'b0);
        chk({tag, " reg_wdata"}, reg_wdata_o, 32'h0);
        chk({tag, " bus_addr"}, bus_addr_o, 32'h0);
        chk({tag, " bus_be"}, {28'h0, bus_be_o}, 32'h0);
    endtask

    txn_t vec[13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0;
        req_valid_i = 1'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
        mem_we_i = 1'b0;
        mem_op_i = '0;
        reg_waddr_i = '0;
        reg_we_i = 1'b0;
        reg_wdata_i = '0;
        bus_ack_i = 1'b0;
        bus_rdata_i = '0;

        // op, we, addr, data, waddr, rwe, rwdata, rdata, delay,
        // bus, mis, be, bus_wdata, wb_we, wb_wdata, chk_wdata
        vec[0]  = '{4'b0000, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 32'h0, 1,
                    1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h1234, 1'b1};
        vec[1]  = '{OP_LB, 1'b0, 32'h1003, 32'h0, 5'd5, 1'b1, 32'h0, 32'h80FF_0000, 3,
                    1'b1, 1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b1};
        vec[2]  = '{OP_LH, 1'b1, 32'h2002, 32'hAAAA_BEEF, 5'd6, 1'b1, 32'h0, 32'h0, 1,
                    1'b1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b1};
        vec[3]  = '{OP_LW, 1'b0, 32'h3001, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0, 1,
                    1'b0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0};
        vec[4]  = '{OP_LBU, 1'b0, 32'h1001, 32'h0, 5'd8, 1'b1, 32'h0, 32'h1234_80FF, 2,
                    1'b1, 1'b0, 4'b0010, 32'h0, 1'b1, 32'h0000_0080, 1'b1};
        vec[5]  = '{OP_LHU, 1'b0, 32'h2002, 32'h0, 5'd9, 1'b1, 32'h0, 32'h8001_0000, 1,
                    1'b1, 1'b0, 4'b1100, 32'h0, 1'b1, 32'h0000_8001, 1'b1};
        vec[6]  = '{OP_LH, 1'b0, 32'h2000, 32'h0, 5'd10, 1'b1, 32'h0, 32'h0000_8001, 1,
                    1'b1, 1'b0, 4'b0011, 32'h0, 1'b1, 32'hFFFF_8001, 1'b1};
        vec[7]  = '{OP_LB, 1'b1, 32'h0006, 32'h0000_00A5, 5'd11, 1'b1, 32'h0, 32'h0, 2,
                    1'b1, 1'b0, 4'b0100, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b1};
        vec[8]  = '{OP_LW, 1'b1, 32'h0008, 32'hDEAD_BEEF, 5'd12, 1'b1, 32'h0, 32'h0, 1,
                    1'b1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1};
        vec[9]  = '{4'b1011, 1'b0, 32'h0, 32'h0, 5'd13, 1'b1, 32'h5555, 32'h0, 1,
                    1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h5555, 1'b1};
        vec[10] = '{OP_LH, 1'b0, 32'h0001, 32'h0, 5'd14, 1'b1, 32'h0, 32'h0, 1,
                    1'b0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0};
        vec[11] = '{OP_LW, 1'b0, 32'h0010, 32'h0, 5'd15, 1'b1, 32'h0, 32'hCAFE_F00D, 1,
                    1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1};
        vec[12] = '{OP_LW, 1'b0, 32'h0014, 32'h0, 5'd16, 1'b0, 32'h0, 32'h1111_2222, 2,
                    1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h1111_2222, 1'b1};

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_idle_zero("reset");
        rst_n_i = 1'b1;

        foreach (vec[i]) run_txn($sformatf("vec%0d", i), vec[i]);

        // Back-to-back pass-through with a stray ack in IDLE, which must be ignored
        @(negedge clk_i);
        req_valid_i = 1'b1;
        mem_op_i = 4'b0000;
        mem_we_i = 1'b0;
        reg_we_i = 1'b1;
        reg_waddr_i = 5'd1;
        reg_wdata_i = 32'hA0A0_0001;
        bus_ack_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chkb("b2b0 wb_valid", wb_valid_o, 1'b1);
        chk("b2b0 reg_wdata", reg_wdata_o, 32'hA0A0_0001);
        reg_waddr_i = 5'd2;
        reg_wdata_i = 32'hB0B0_0002;
        @(posedge clk_i);
        @(negedge clk_i);
        chkb("b2b1 wb_valid", wb_valid_o, 1'b1);
        chk("b2b1 reg_wdata", reg_wdata_o, 32'hB0B0_0002);
        chk("b2b1 reg_waddr", {27'h0, reg_waddr_o}, 32'd2);
        chkb("b2b1 bus_req", bus_req_o, 1'b0);
        chkb("b2b1 stall", stall_o, 1'b0);
        req_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        chk_idle_zero("b2b idle");

        // Reset while an access is in flight; a later ack must not produce a writeback
        @(negedge clk_i);
        req_valid_i = 1'b1;
        mem_op_i = OP_LW;
        mem_we_i = 1'b0;
        mem_addr_i = 32'h0000_0040;
        reg_we_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chkb("midrst bus_req before", bus_req_o, 1'b1);
        rst_n_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk_idle_zero("midrst reset");
        rst_n_i = 1'b1;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h7777_7777;
        repeat (2) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk_idle_zero("midrst ack");
        end
        bus_ack_i = 1'b0;

`ifdef MEM_LSU_TIMEOUT_EN
        // No ack: bus_req held for 4 cycles, then error writeback
        @(negedge clk_i);
        req_valid_i = 1'b1;
        mem_op_i = OP_LW;
        mem_we_i = 1'b0;
        mem_addr_i = 32'h0000_0080;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chkb("tmo bus_req", bus_req_o, 1'b1);
            chkb("tmo bus_err early", bus_err_o, 1'b0);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        chkb("tmo bus_req dropped", bus_req_o, 1'b0);
        chkb("tmo bus_err", bus_err_o, 1'b1);
        chkb("tmo wb_valid", wb_valid_o, 1'b1);
        chkb("tmo reg_we", reg_we_o, 1'b0);
        @(negedge clk_i);
        chkb("tmo bus_err clear", bus_err_o, 1'b0);
        chkb("tmo req_ready", req_ready_o, 1'b1);
`endif

        // Randomized transactions against the reference model
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  op;
            logic        we;
            logic [31:0] addr;
            txn_t        t;
            op = 4'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            if (we && op[3] && op[2]) op[2] = 1'b0;
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            t = model(op, we, addr, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(1, 4));
            run_txn($sformatf("rnd%0d", n), t);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit; the responder for the execute stage's memory requests (mem_addr/mem_data/mem_we/mem_op).
- Accepts one request at a time and drives a single-outstanding req/ack data bus.
- Applies store byte lanes and load extraction with sign/zero extension, then presents the writeback to the mem/wb register.
- Stalls the pipeline while a bus access is in flight.

Parameters:
- DATA_WIDTH, 32, data/address width (fixed 32 for byte-lane logic)
- RADDR_WIDTH, 5, register address width
- TIMEOUT_CYCLES, 64, bus ack timeout (used only with MEM_LSU_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request from exe/mem register
- req_ready_o  out  1  request accepted this cycle
- mem_addr_i  in  32  byte address
- mem_data_i  in  32  store data
- mem_we_i  in  1  1=store, 0=load
- mem_op_i  in  4  [3]=mem access, [2:0]=funct3; 4'b0xxx = no access (ALU pass-through)
- reg_waddr_i  in  5  destination register
- reg_we_i  in  1  writeback enable
- reg_wdata_i  in  32  ALU result, used for pass-through
- wb_valid_o  out  1  writeback fields valid (one-cycle pulse)
- reg_waddr_o  out  5
- reg_we_o  out  1
- reg_wdata_o  out  32
- stall_o  out  1  freeze upstream stages
- misalign_o  out  1  one-cycle pulse, misaligned access dropped
- bus_req_o  out  1
- bus_we_o  out  1
- bus_addr_o  out  32  word-aligned address, [1:0]=0
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32
- bus_ack_i  in  1
- bus_rdata_i  in  32
- bus_err_o  out  1  present only with MEM_LSU_TIMEOUT_EN

Behaviour:
- Decided interface: one clock clk_i; reset rst_n_i is synchronous and active-low.
- Reset (rst_n_i=0 at a clock edge): state=IDLE. All outputs are 0 except req_ready_o=1. Any in-flight access is abandoned; a later bus_ack_i is ignored.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1, stall_o=0; acceptance = req_valid_i & req_ready_o.
  - Accept with mem_op_i[3]=0: next cycle wb_valid_o=1 with reg_waddr_i, reg_we_i and reg_wdata_i registered; stay in IDLE. Latency 1; back-to-back pass-through is allowed.
  - Accept with a misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): next cycle misalign_o=1, wb_valid_o=1, reg_we_o=0; no bus access.
  - Accept with a valid access: latch the request, enter BUS.
- BUS:
  - bus_req_o=1 and bus fields held stable until bus_ack_i=1.
  - stall_o=1, req_ready_o=0.
  - On ack: enter RESP; capture bus_rdata_i for a load.
- RESP (one cycle):
  - wb_valid_o=1.
  - Load: reg_we_o=latched reg_we, reg_wdata_o=extracted data.
  - Store: reg_we_o=0, reg_wdata_o=0.
  - stall_o=0, req_ready_o=0; return to IDLE.
- Minimum memory latency: 2 cycles from accept to wb_valid_o (ack in the first BUS cycle).
- bus_ack_i outside BUS is ignored.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}
  - SW: be=4'b1111, wdata=data
- Load extract (byte/half selected by addr[1:0]):
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- mem_op_i[3]=1 with an undefined funct3 (3, 6, 7): treated as pass-through with reg_we_o=0.

Optional Feature:
- Macro: MEM_LSU_TIMEOUT_EN.
- With it: a counter runs in BUS. When it reaches TIMEOUT_CYCLES without an ack:
  - bus_req_o drops;
  - next cycle bus_err_o=1 and wb_valid_o=1 with reg_we_o=0;
  - return to IDLE.
- Without it: BUS waits indefinitely, the bus_err_o port is absent, and no counter is synthesized.

Decomposition:
- Shared defines package holds:
  - the mem_op encodings (LB=4'b1000, LH=4'b1001, LW=4'b1010, LBU=4'b1100, LHU=4'b1101, SB/SH/SW share funct3 with mem_we_i=1);
  - FSM state constants;
  - ZERO, ZERO_REG, WRITE_DISABLE.
- One combinational sub-module, lsu_lane_fmt: store byte-enable/data replication and load extract/extend.

Test Plan:
- Pass-through: mem_op=4'b0000, reg_wdata=32'h1234 -> next cycle wb_valid_o=1, reg_wdata_o=32'h1234, bus_req_o stays 0.
- LB: addr=32'h1003, bus_rdata=32'h80FF_0000, ack after 3 cycles -> bus_addr_o=32'h1000, bus_be_o=4'b1000, reg_wdata_o=32'hFFFF_FF80; stall_o=1 for 3 cycles.
- SH: addr=32'h2002, data=32'hAAAA_BEEF -> bus_be_o=4'b1100, bus_wdata_o=32'hBEEF_BEEF, reg_we_o=0 in RESP.
- Misaligned LW: addr=32'h3001 -> misalign_o=1 for one cycle, no bus_req_o, reg_we_o=0.
- Mid-access reset: rst_n_i=0 in BUS, then an ack is raised -> all outputs 0, req_ready_o=1, no wb_valid_o.
- Timeout (MEM_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> bus_req_o falls after 4 cycles, then bus_err_o=1 and wb_valid_o=1.
